// File: rtl/i2s_rx.sv
// I2S slave receiver: brings externally mastered BCK/LRCK/DIN into the clk domain
// and assembles MSB-first left/right words into sample pairs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_HUNT  | not aligned; waiting for an LRCK 1->0 boundary
// ST_LEFT  | collecting the left word (LRCK low)
// ST_RIGHT | collecting the right word (LRCK high); left word is held
module i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bck,
  input  logic              lrck,
  input  logic              din,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   bck_prev_q, bck_prev_d;
  logic                   lrck_prev_q, lrck_prev_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      left_hold_q, left_hold_d;
  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W-1:0]      right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;

  logic                   bck_s, lrck_s, din_s;
  logic                   rise;
  logic                   word_ok;
  logic [DATA_W-1:0]      shift_nxt;
  logic [CNT_W-1:0]       cnt_nxt;

  assign bck_s  = bck_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  assign rise   = bck_s & ~bck_prev_q;

  always_comb begin
    bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], bck};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], lrck};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
    bck_prev_d  = bck_s;

    lrck_prev_d = lrck_prev_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    shift_nxt   = shift_q;
    cnt_nxt     = bit_cnt_q;
    word_ok     = 1'b0;

    if (rise) begin
      // Bits beyond DATA_W in a long slot are dropped; the count saturates.
      if (bit_cnt_q != CNT_FULL) begin
        shift_nxt = {shift_q[DATA_W-2:0], din_s};
        cnt_nxt   = bit_cnt_q + CNT_W'(1);
      end
      lrck_prev_d = lrck_s;
      shift_d     = shift_nxt;
      bit_cnt_d   = cnt_nxt;

      // The bit on the LRCK-change edge is the LSB of the word that just ended.
      if (lrck_s != lrck_prev_q) begin
        word_ok   = (cnt_nxt == CNT_FULL);
        shift_d   = '0;
        bit_cnt_d = '0;
        case (state_q)
          ST_HUNT: begin
            if (!lrck_s) state_d = ST_LEFT;
          end
          ST_LEFT: begin
            if (word_ok) begin
              left_hold_d = shift_nxt;
              state_d     = ST_RIGHT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end
          end
          ST_RIGHT: begin
            if (word_ok) begin
              left_d  = left_hold_q;
              right_d = shift_nxt;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = ST_LEFT;
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end

    locked_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      din_sync_q  <= '0;
      bck_prev_q  <= 1'b0;
      lrck_prev_q <= 1'b0;
      state_q     <= ST_HUNT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      bck_sync_q  <= bck_sync_d;
      lrck_sync_q <= lrck_sync_d;
      din_sync_q  <= din_sync_d;
      bck_prev_q  <= bck_prev_d;
      lrck_prev_q <= lrck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: plays slot-level I2S streams and compares the output event
// sequence with a slot-level reference model.
module tb_i2s_rx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bck = 1'b0;
  logic          lrck = 1'b0;
  logic          din = 1'b0;
  logic [DW-1:0] left, right;
  logic          sample_valid, frame_err, locked;

  int n_pass = 0;
  int n_total = 0;

  i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din),
    .left(left), .right(right), .sample_valid(sample_valid),
    .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  // Observed events: {is_err, locked, left, right}
  logic [33:0]   obs_q[$];
  int            viol = 0;
  int            lock_rises = 0;
  logic [DW-1:0] prev_left = '0, prev_right = '0;
  logic          prev_locked = 1'b0;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) obs_q.push_back({1'b0, locked, left, right});
    if (frame_err === 1'b1) obs_q.push_back({1'b1, locked, 16'h0, 16'h0});
    if (sample_valid === 1'b1 && frame_err === 1'b1) viol++;
    if (!rst && sample_valid !== 1'b1 && (left !== prev_left || right !== prev_right)) viol++;
    if (locked === 1'b1 && !prev_locked) lock_rises++;
    prev_left   = left;
    prev_right  = right;
    prev_locked = (locked === 1'b1);
  end

  int          s_len[$];
  logic [31:0] s_word[$];
  bit          s_lr0;
  bit          lr_q[$], d_q[$];
  logic [33:0] exp_q[$];
  int          exp_rises;

  task automatic new_stream(input bit lr0);
    s_len.delete();
    s_word.delete();
    s_lr0 = lr0;
  endtask

  task automatic add_slot(input int n, input logic [31:0] w);
    s_len.push_back(n);
    s_word.push_back(w);
  endtask

  function automatic logic [31:0] rnd_word(input int n);
    logic [31:0] m;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    return $urandom() & m;
  endfunction

  // Slot-level model: a slot ends at the next LRCK change; a word is good when
  // its slot holds at least DW bits, and only its top DW bits are kept.
  task automatic build_and_model();
    bit            bits[$];
    bit            aligned, cur;
    logic [15:0]   hold, top;
    lr_q.delete(); d_q.delete(); exp_q.delete();
    exp_rises = 0; aligned = 1'b0; hold = '0;
    for (int j = 0; j < s_len.size(); j++) begin
      cur = s_lr0 ^ bit'(j % 2);
      for (int k = s_len[j] - 1; k >= 0; k--) begin
        bits.push_back(s_word[j][k]);
        lr_q.push_back(cur);
      end
      top = (s_len[j] >= DW) ? 16'(s_word[j] >> (s_len[j] - DW)) : 16'h0;
      if (!aligned) begin
        if (cur) begin aligned = 1'b1; exp_rises++; end
      end else if (!cur) begin
        if (s_len[j] >= DW) hold = top;
        else begin exp_q.push_back({1'b1, 1'b0, 32'h0}); aligned = 1'b0; end
      end else begin
        if (s_len[j] >= DW) exp_q.push_back({2'b01, hold, top});
        else exp_q.push_back({2'b11, 32'h0});
      end
    end
    // Short filler slot so the last real word sees its closing LRCK edge.
    cur = s_lr0 ^ bit'(s_len.size() % 2);
    repeat (2) begin bits.push_back(1'b0); lr_q.push_back(cur); end
    d_q.push_back(1'b0);
    for (int i = 0; i < bits.size() - 1; i++) d_q.push_back(bits[i]);
  endtask

  // Data/LRCK change on BCK falling edge; one-bit I2S delay is already in d_q.
  task automatic drive_stream(input int half, input int from, input int upto);
    for (int i = from; i < lr_q.size() && i < upto; i++) begin
      @(negedge clk);
      bck = 1'b0; lrck = lr_q[i]; din = d_q[i];
      repeat (half) @(negedge clk);
      bck = 1'b1;
      repeat (half - 1) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    bck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bck = 1'b0; lrck = 1'b0; din = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (left !== 16'h0) $display("FAIL reset_left: got %h want 0000", left); else n_pass++;
    n_total++; if (right !== 16'h0) $display("FAIL reset_right: got %h want 0000", right); else n_pass++;
    n_total++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
  endtask

  task automatic test_slot32();
    int base;
    apply_reset();
    new_stream(1'b0);
    repeat (4) begin
      add_slot(32, {16'h8001, 16'($urandom())});
      add_slot(32, {16'h7FFE, 16'($urandom())});
    end
    build_and_model();
    base = obs_q.size();
    drive_stream(16, 0, lr_q.size());
    settle();
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL slot32_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL slot32_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
    n_total++; if (left !== 16'h8001) $display("FAIL slot32_left: got %h want 8001", left); else n_pass++;
    n_total++; if (right !== 16'h7FFE) $display("FAIL slot32_right: got %h want 7ffe", right); else n_pass++;
  endtask

  task automatic test_mid_start();
    int base, rises0, half;
    half = $urandom_range(6, 2);
    apply_reset();
    new_stream(1'b1);
    add_slot(10, rnd_word(10));
    repeat (3) begin add_slot(32, rnd_word(32)); add_slot(32, rnd_word(32)); end
    build_and_model();
    base = obs_q.size();
    rises0 = lock_rises;
    drive_stream(half, 0, 10);
    repeat (6) @(negedge clk);
    n_total++; if (locked !== 1'b0) $display("FAIL mid_pre_lock: got %b want 0", locked); else n_pass++;
    drive_stream(half, 10, 11);
    repeat (6) @(negedge clk);
    n_total++; if (locked !== 1'b1) $display("FAIL mid_post_lock: got %b want 1", locked); else n_pass++;
    drive_stream(half, 11, lr_q.size());
    settle();
    n_total++; if (lock_rises - rises0 !== exp_rises) $display("FAIL mid_rises: got %0d want %0d", lock_rises - rises0, exp_rises); else n_pass++;
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL mid_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL mid_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_slot16();
    int base;
    apply_reset();
    new_stream(1'b0);
    repeat (2) begin add_slot(16, 32'hA5A5); add_slot(16, 32'h0001); end
    repeat (2) begin add_slot(16, rnd_word(16)); add_slot(16, rnd_word(16)); end
    build_and_model();
    base = obs_q.size();
    drive_stream($urandom_range(6, 2), 0, lr_q.size());
    settle();
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL s16_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL s16_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_short_slot();
    int base, rises0;
    apply_reset();
    new_stream(1'b1);
    add_slot(32, rnd_word(32));
    add_slot(32, rnd_word(32)); add_slot(32, rnd_word(32));
    add_slot(12, rnd_word(12)); add_slot(32, rnd_word(32));
    add_slot(32, rnd_word(32)); add_slot(32, rnd_word(32));
    build_and_model();
    base = obs_q.size();
    rises0 = lock_rises;
    drive_stream($urandom_range(6, 2), 0, lr_q.size());
    settle();
    n_total++; if (lock_rises - rises0 !== exp_rises) $display("FAIL short_rises: got %0d want %0d", lock_rises - rises0, exp_rises); else n_pass++;
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL short_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL short_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_long_slot();
    int base;
    apply_reset();
    new_stream(1'b0);
    repeat (3) begin add_slot(24, 32'h123456); add_slot(24, rnd_word(24)); end
    build_and_model();
    base = obs_q.size();
    drive_stream($urandom_range(6, 2), 0, lr_q.size());
    settle();
    n_total++; if (left !== 16'h1234) $display("FAIL long_left: got %h want 1234", left); else n_pass++;
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL long_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL long_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word();
    int base, half;
    half = $urandom_range(6, 2);
    apply_reset();
    new_stream(1'b0);
    repeat (3) begin add_slot(32, rnd_word(32)); add_slot(32, rnd_word(32)); end
    build_and_model();
    drive_stream(half, 0, 106);
    repeat (3) @(negedge clk);
    n_total++; if (locked !== 1'b1) $display("FAIL rmid_pre_lock: got %b want 1", locked); else n_pass++;
    rst = 1'b1; bck = 1'b0; lrck = 1'b0; din = 1'b0;
    @(negedge clk);
    n_total++; if (left !== 16'h0) $display("FAIL rmid_left: got %h want 0000", left); else n_pass++;
    n_total++; if (right !== 16'h0) $display("FAIL rmid_right: got %h want 0000", right); else n_pass++;
    n_total++; if ({sample_valid, frame_err} !== 2'b00) $display("FAIL rmid_pulses: got %b want 00", {sample_valid, frame_err}); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL rmid_locked: got %b want 0", locked); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    new_stream(1'b0);
    repeat (3) begin add_slot(32, rnd_word(32)); add_slot(32, rnd_word(32)); end
    build_and_model();
    base = obs_q.size();
    drive_stream(half, 0, lr_q.size());
    settle();
    n_total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL rmid_count: got %0d events want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_total++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL rmid_ev%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_total++; if (viol !== 0) $display("FAIL invariants: got %0d violations want 0", viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_slot32();
    test_mid_start();
    test_slot16();
    test_short_slot();
    test_long_slot();
    test_reset_mid_word();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
